// File: rtl/processor_regfile_sb_if.sv
// processor_regfile_sb_if: issue/writeback bus of the scoreboarded register file
interface processor_regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  logic                     ClkEn_e;
  logic                     RegWrt_c;
  logic [ADDR_W-1:0]        Rd_i;
  logic [DATA_W-1:0]        Dat_i;
  logic [NUM_RD*ADDR_W-1:0] Rs_i;
  logic [NUM_RD*DATA_W-1:0] Rs_o;
  logic                     Rsv_c;
  logic [ADDR_W-1:0]        RsvAddr_i;
  logic [NUM_RD-1:0]        Busy_o;
  logic                     RsvBusy_o;
  logic                     Stall_o;
  logic [ADDR_W:0]          PendCnt_o;
  modport master (
    output ClkEn_e, RegWrt_c, Rd_i, Dat_i, Rs_i, Rsv_c, RsvAddr_i,
    input  Rs_o, Busy_o, RsvBusy_o, Stall_o, PendCnt_o
  );
  modport slave (
    input  ClkEn_e, RegWrt_c, Rd_i, Dat_i, Rs_i, Rsv_c, RsvAddr_i,
    output Rs_o, Busy_o, RsvBusy_o, Stall_o, PendCnt_o
  );
endinterface

// File: rtl/processor_regfile_sb.sv
// processor_regfile_sb: register file with write-to-read bypass and busy-bit scoreboard.
// `REGFILE_ZERO_REG_EN makes r0 a hardwired zero that can never be written or reserved.
module processor_regfile_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input logic Clk_i,
  input logic Rst_i,
  processor_regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [NUM_RD-1:0] busy_rd;
  logic wr_fire, wr_en, rsv_fire, rsv_set, rsv_busy, stall, inc, dec;
  assign wr_fire = bus.ClkEn_e & bus.RegWrt_c;
`ifdef REGFILE_ZERO_REG_EN
  assign wr_en   = wr_fire & (bus.Rd_i != '0);
  assign rsv_set = rsv_fire & (bus.RsvAddr_i != '0);
`else
  assign wr_en   = wr_fire;
  assign rsv_set = rsv_fire;
`endif
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rs;
    logic hit;
    assign rs = bus.Rs_i[k*ADDR_W +: ADDR_W];
    assign hit = wr_en & (bus.Rd_i == rs);
    assign bus.Rs_o[k*DATA_W +: DATA_W] = hit ? bus.Dat_i : regs_q[rs];
    assign busy_rd[k] = busy_q[rs] & ~hit;
  end
  assign rsv_busy = busy_q[bus.RsvAddr_i] & ~(wr_en & (bus.Rd_i == bus.RsvAddr_i));
  assign stall    = bus.Rsv_c & (|busy_rd | rsv_busy);
  assign rsv_fire = bus.ClkEn_e & bus.Rsv_c & ~stall;
  // a same-address reserve overrides the writeback's busy clear
  assign inc = rsv_set & ~busy_q[bus.RsvAddr_i];
  assign dec = wr_en & busy_q[bus.Rd_i] & ~(rsv_set & (bus.RsvAddr_i == bus.Rd_i));
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[bus.Rd_i] = 1'b0;
    if (rsv_set) busy_d[bus.RsvAddr_i] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[bus.Rd_i] <= bus.Dat_i;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.Busy_o    = busy_rd;
  assign bus.RsvBusy_o = rsv_busy;
  assign bus.Stall_o   = stall;
  assign bus.PendCnt_o = cnt_q;
endmodule

// File: tb/tb_processor_regfile_sb.sv
// tb_processor_regfile_sb: directed vector table, corner sequences and randomized model check
module tb_processor_regfile_sb;
  localparam int DW = 8, AW = 3, NR = 2, D = 8;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  processor_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();
  processor_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .Clk_i(clk),
    .Rst_i(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic en, wr;
    logic [2:0] rd;
    logic [7:0] dat;
    logic [5:0] rs;
    logic rsv;
    logic [2:0] ra;
    logic [15:0] ers;
    logic [1:0] eb;
    logic erb, est;
    logic [3:0] ecnt;
  } vec_t;
  vec_t tab [18];
  int n_chk = 0, n_fail = 0;
  logic [7:0] mreg [D];
  bit mbusy [D];
  logic ren, rwr, rrsv, erb, est, wf;
  logic [2:0] rrd, rra;
  logic [7:0] rdat;
  logic [5:0] rrs;
  logic [15:0] ers;
  logic [1:0] eb;
  int cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [2:0] rd, input logic [7:0] dat,
                       input logic [5:0] rs, input logic rsv, input logic [2:0] ra);
    bus.ClkEn_e = en; bus.RegWrt_c = wr; bus.Rd_i = rd; bus.Dat_i = dat;
    bus.Rs_i = rs; bus.Rsv_c = rsv; bus.RsvAddr_i = ra;
  endtask

  function automatic logic [7:0] mread(input logic [2:0] a);
    if (ZERO && a == 0) return 8'h00;
    return (wf && rrd == a) ? rdat : mreg[a];
  endfunction

  function automatic bit mbsy(input logic [2:0] a);
    return mbusy[a] && !(wf && rrd == a && !(ZERO && a == 0));
  endfunction

  initial begin
    tab = '{
      '{1'b0,1'b0,3'd0,8'h00,{3'd0,3'd0},1'b0,3'd0,16'h0000,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b1,3'd0,8'hFF,{3'd2,3'd1},1'b0,3'd0,16'h0000,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b1,3'd1,8'hFE,{3'd2,3'd1},1'b0,3'd0,16'h00FE,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b1,3'd2,8'hAA,{3'd2,3'd1},1'b0,3'd0,16'hAAFE,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b0,3'd0,8'h00,{3'd3,3'd1},1'b0,3'd0,16'h00FE,2'b00,1'b0,1'b0,4'd0},
      '{1'b0,1'b1,3'd5,8'h5A,{3'd2,3'd5},1'b0,3'd0,16'hAA00,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b0,3'd0,8'h00,{3'd2,3'd5},1'b0,3'd0,16'hAA00,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b1,3'd5,8'h5A,{3'd2,3'd5},1'b0,3'd0,16'hAA5A,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b0,3'd0,8'h00,{3'd5,3'd5},1'b0,3'd0,16'h5A5A,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b0,3'd0,8'h00,{3'd1,3'd1},1'b1,3'd4,16'hFEFE,2'b00,1'b0,1'b0,4'd1},
      '{1'b1,1'b0,3'd0,8'h00,{3'd1,3'd4},1'b1,3'd7,16'hFE00,2'b01,1'b0,1'b1,4'd1},
      '{1'b1,1'b1,3'd4,8'h33,{3'd1,3'd4},1'b1,3'd7,16'hFE33,2'b00,1'b0,1'b0,4'd1},
      '{1'b1,1'b1,3'd7,8'h07,{3'd7,3'd4},1'b0,3'd0,16'h0733,2'b00,1'b0,1'b0,4'd0},
      '{1'b1,1'b0,3'd0,8'h00,{3'd6,3'd6},1'b1,3'd6,16'h0000,2'b00,1'b0,1'b0,4'd1},
      '{1'b1,1'b0,3'd0,8'h00,{3'd1,3'd1},1'b1,3'd6,16'hFEFE,2'b00,1'b1,1'b1,4'd1},
      '{1'b1,1'b1,3'd6,8'h66,{3'd6,3'd1},1'b1,3'd6,16'h66FE,2'b00,1'b0,1'b0,4'd1},
      '{1'b1,1'b0,3'd0,8'h00,{3'd6,3'd1},1'b0,3'd0,16'h66FE,2'b10,1'b0,1'b0,4'd1},
      '{1'b0,1'b0,3'd0,8'h00,{3'd6,3'd1},1'b1,3'd6,16'h66FE,2'b10,1'b1,1'b1,4'd1}
    };
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (tab[i]) begin
      drive(tab[i].en, tab[i].wr, tab[i].rd, tab[i].dat, tab[i].rs, tab[i].rsv, tab[i].ra);
      #1;
      chk($sformatf("vec%0d Rs_o", i), bus.Rs_o, tab[i].ers);
      chk($sformatf("vec%0d Busy_o", i), bus.Busy_o, tab[i].eb);
      chk($sformatf("vec%0d RsvBusy_o", i), bus.RsvBusy_o, tab[i].erb);
      chk($sformatf("vec%0d Stall_o", i), bus.Stall_o, tab[i].est);
      @(posedge clk);
      #1 chk($sformatf("vec%0d PendCnt_o", i), bus.PendCnt_o, tab[i].ecnt);
    end
    // fill every remaining register (r6 is still pending)
    for (int i = 0; i < D; i++) begin
      if (i == 6) continue;
      drive(1, 0, 0, 0, {3'(i), 3'(i)}, 1, 3'(i));
      #1 chk($sformatf("fill%0d Stall_o", i), bus.Stall_o, 0);
      @(posedge clk);
      #1;
    end
    chk("fill PendCnt_o", bus.PendCnt_o, ZERO ? 7 : 8);
    drive(1, 0, 0, 0, {3'd6, 3'd6}, 1, 3'd6);
    #1 chk("pre-reset Stall_o", bus.Stall_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst PendCnt_o", bus.PendCnt_o, 0);
    chk("async rst Busy_o", bus.Busy_o, 0);
    chk("async rst RsvBusy_o", bus.RsvBusy_o, 0);
    chk("async rst Stall_o", bus.Stall_o, 0);
    chk("async rst Rs_o", bus.Rs_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // r0 behaviour with and without the hardwired-zero build
    drive(1, 1, 0, 8'h77, {3'd0, 3'd0}, 0, 0);
    #1 chk("r0 bypass Rs_o", bus.Rs_o, ZERO ? 16'h0000 : 16'h7777);
    @(posedge clk);
    #1 drive(1, 0, 0, 0, {3'd0, 3'd0}, 1, 0);
    #1;
    chk("r0 read Rs_o", bus.Rs_o, ZERO ? 16'h0000 : 16'h7777);
    chk("r0 rsv Stall_o", bus.Stall_o, 0);
    @(posedge clk);
    #1 chk("r0 rsv PendCnt_o", bus.PendCnt_o, ZERO ? 0 : 1);
    drive(1, 0, 0, 0, {3'd1, 3'd1}, 1, 0);
    #1 chk("r0 re-rsv Stall_o", bus.Stall_o, ZERO ? 0 : 1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin mreg[i] = 8'h00; mbusy[i] = 1'b0; end
    for (int n = 0; n < 500; n++) begin
      ren = ($urandom_range(0, 99) < 85);
      rwr = $urandom_range(0, 1) == 1;
      rrsv = $urandom_range(0, 1) == 1;
      rrd = 3'($urandom);
      rra = 3'($urandom);
      rdat = 8'($urandom);
      rrs = 6'($urandom);
      drive(ren, rwr, rrd, rdat, rrs, rrsv, rra);
      #1;
      wf = ren & rwr;
      for (int k = 0; k < NR; k++) begin
        ers[k*8 +: 8] = mread(rrs[k*3 +: 3]);
        eb[k] = mbsy(rrs[k*3 +: 3]);
      end
      erb = mbsy(rra);
      est = rrsv && (eb != 0 || erb);
      chk($sformatf("rnd%0d Rs_o", n), bus.Rs_o, ers);
      chk($sformatf("rnd%0d Busy_o", n), bus.Busy_o, eb);
      chk($sformatf("rnd%0d RsvBusy_o", n), bus.RsvBusy_o, erb);
      chk($sformatf("rnd%0d Stall_o", n), bus.Stall_o, est);
      @(posedge clk);
      if (wf && !(ZERO && rrd == 0)) begin mreg[rrd] = rdat; mbusy[rrd] = 1'b0; end
      if (ren && rrsv && !est && !(ZERO && rra == 0)) mbusy[rra] = 1'b1;
      cnt = 0;
      for (int i = 0; i < D; i++) cnt += int'(mbusy[i]);
      #1 chk($sformatf("rnd%0d PendCnt_o", n), bus.PendCnt_o, cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
